// File: rtl/memory_pkg.sv
// Shared types and constants for the latency-emulating unified memory.
package memory_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned NUM_BYTES   = WORD_W / BYTE_W;
  localparam int unsigned CNT_W       = 5;
  localparam int unsigned MAX_LATENCY = 31;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    READ_WAIT  = 2'b01,
    WRITE_WAIT = 2'b10
  } mem_state_e;

  // Write payload captured at acceptance and held until commit.
  typedef struct packed {
    logic [NUM_BYTES-1:0] be;
    word_t                data;
  } wr_payload_t;

  // Replace the enabled byte lanes of old_w with those of new_w.
  function automatic word_t merge_bytes(input word_t old_w, input word_t new_w,
                                        input logic [NUM_BYTES-1:0] be);
    word_t w;
    w = old_w;
    for (int unsigned b = 0; b < NUM_BYTES; b++) begin
      if (be[b]) w[b*BYTE_W +: BYTE_W] = new_w[b*BYTE_W +: BYTE_W];
    end
    return w;
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Latency counter: load starts at 1 with a new target, tc marks the target edge.
module mem_wait_counter
  import memory_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] target_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] target_q;
  logic [CNT_W-1:0] count_inc_c;
  logic             tc_q;

  assign count_inc_c = count_q + CNT_W'(1);

  // Count register; tc is precomputed so it is high while count equals target.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q  <= '0;
      target_q <= '0;
      tc_q     <= 1'b0;
    end else if (load_i) begin
      count_q  <= CNT_W'(1);
      target_q <= target_i;
      tc_q     <= (target_i == CNT_W'(1));
    end else if (en_i) begin
      count_q  <= count_inc_c;
      tc_q     <= (count_inc_c == target_q);
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/latency_memory.sv
// Unified word memory: 1-cycle fetch port plus a handshaked data port with
// configurable read/write latency, byte enables and range error reporting.
module latency_memory
  import memory_pkg::*;
#(
  parameter int unsigned DEPTH         = 1024,
  parameter int unsigned ADDR_BITS     = 12,
  parameter int unsigned READ_LATENCY  = 7,
  parameter int unsigned WRITE_LATENCY = 1,
  parameter string       INIT_FILE     = ""
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] pc,
  output logic [WORD_W-1:0]    instr,
  input  logic [ADDR_BITS-1:0] data_addr,
  input  logic                 ren,
  input  logic                 wen,
  input  logic [WORD_W-1:0]    data_in,
  input  logic [NUM_BYTES-1:0] byte_select_vector,
  output logic [WORD_W-1:0]    data_out,
  output logic                 ready,
  output logic                 data_valid,
  output logic                 write_done,
  output logic                 error
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Depth at one bit wider than the address so DEPTH == 2**ADDR_BITS still fits.
  localparam logic [ADDR_BITS:0] DEPTH_X = (ADDR_BITS+1)'(DEPTH);

  // Reject illegal parameter sets at elaboration.
  if (DEPTH == 0 || ADDR_BITS == 0 || ADDR_BITS > 31 ||
      (64'(1) << ADDR_BITS) < 64'(DEPTH) ||
      READ_LATENCY < 1 || READ_LATENCY > MAX_LATENCY ||
      WRITE_LATENCY < 1 || WRITE_LATENCY > MAX_LATENCY) begin : g_param_check
    $fatal(1, "latency_memory: illegal DEPTH/ADDR_BITS/latency parameters");
  end

  function automatic logic in_range(input logic [ADDR_BITS-1:0] a);
    return {1'b0, a} < DEPTH_X;
  endfunction

  word_t        mem_q [DEPTH];

  mem_state_e   state_q;
  logic [ADDR_BITS-1:0] addr_q;
  wr_payload_t  wr_q;
  word_t        data_out_q;
  word_t        instr_q;
  logic         ready_q;
  logic         data_valid_q;
  logic         write_done_q;
  logic         error_q;

  logic         rd_req_c;
  logic         wr_req_c;
  logic         cnt_load_c;
  logic         cnt_en_c;
  logic [CNT_W-1:0] cnt_target_c;
  logic         cnt_tc;
  logic         addr_ok_c;
  logic [IDX_W-1:0] addr_idx_c;
  logic [IDX_W-1:0] pc_idx_c;
  logic         commit_c;

  // Array power-up contents: all zero.
  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) mem_q[IDX_W'(i)] = '0;
  end

  assign rd_req_c     = ready_q & ren & ~wen;
  assign wr_req_c     = ready_q & wen & ~ren;
  assign cnt_load_c   = rd_req_c | wr_req_c;
  assign cnt_en_c     = (state_q != IDLE);
  assign cnt_target_c = rd_req_c ? CNT_W'(READ_LATENCY) : CNT_W'(WRITE_LATENCY);
  assign addr_ok_c    = in_range(addr_q);
  assign addr_idx_c   = IDX_W'(addr_q);
  assign pc_idx_c     = IDX_W'(pc);
  assign commit_c     = (state_q == WRITE_WAIT) & cnt_tc & addr_ok_c;

  mem_wait_counter u_wait_counter (
    .clk_i    (clk),
    .rst_i    (reset),
    .load_i   (cnt_load_c),
    .en_i     (cnt_en_c),
    .target_i (cnt_target_c),
    .tc_o     (cnt_tc)
  );

  // Data-port FSM: accept, wait out the latency, then pulse the response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wr_q         <= '0;
      data_out_q   <= '0;
      ready_q      <= 1'b1;
      data_valid_q <= 1'b0;
      write_done_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      write_done_q <= 1'b0;
      error_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rd_req_c) begin
            state_q <= READ_WAIT;
            ready_q <= 1'b0;
            addr_q  <= data_addr;
          end else if (wr_req_c) begin
            state_q <= WRITE_WAIT;
            ready_q <= 1'b0;
            addr_q  <= data_addr;
            wr_q    <= '{be: byte_select_vector, data: data_in};
          end else if (ren && wen) begin
            error_q <= 1'b1;
          end
        end
        READ_WAIT: begin
          if (cnt_tc) begin
            data_out_q   <= addr_ok_c ? mem_q[addr_idx_c] : '0;
            data_valid_q <= 1'b1;
            error_q      <= ~addr_ok_c;
            ready_q      <= 1'b1;
            state_q      <= IDLE;
          end
        end
        WRITE_WAIT: begin
          if (cnt_tc) begin
            write_done_q <= 1'b1;
            error_q      <= ~addr_ok_c;
            ready_q      <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Array write at the commit edge; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (commit_c) begin
      mem_q[addr_idx_c] <= merge_bytes(mem_q[addr_idx_c], wr_q.data, wr_q.be);
    end
  end

  // Instruction fetch, read-before-write against a same-edge commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= '0;
    end else begin
      instr_q <= in_range(pc) ? mem_q[pc_idx_c] : '0;
    end
  end

  assign instr      = instr_q;
  assign data_out   = data_out_q;
  assign ready      = ready_q;
  assign data_valid = data_valid_q;
  assign write_done = write_done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_latency_memory.sv
// Randomized self-checking bench for latency_memory against an array model.
module tb_latency_memory;

  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned RD_LAT = 7;
  localparam int unsigned WR_LAT = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] pc;
  logic [31:0] instr;
  logic [11:0] data_addr;
  logic        ren;
  logic        wen;
  logic [31:0] data_in;
  logic [3:0]  bsv;
  logic [31:0] data_out;
  logic        ready;
  logic        data_valid;
  logic        write_done;
  logic        error;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] last_dout;
  logic        pc_hold;

  always #5 clk = ~clk;

  latency_memory #(
    .DEPTH         (DEPTH),
    .ADDR_BITS     (12),
    .READ_LATENCY  (RD_LAT),
    .WRITE_LATENCY (WR_LAT),
    .INIT_FILE     ("")
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .pc                 (pc),
    .instr              (instr),
    .data_addr          (data_addr),
    .ren                (ren),
    .wen                (wen),
    .data_in            (data_in),
    .byte_select_vector (bsv),
    .data_out           (data_out),
    .ready              (ready),
    .data_valid         (data_valid),
    .write_done         (write_done),
    .error              (error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [11:0] a);
    if (32'(a) < DEPTH) return model_mem[a[9:0]];
    return 32'h0;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] w;
    w = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
    return w;
  endfunction

  // Mostly a small hot window (hazards), some full range, some out of range.
  function automatic logic [11:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 6) return 12'($urandom_range(0, 15));
    if (r < 9) return 12'($urandom_range(0, 1023));
    return 12'($urandom_range(1024, 4095));
  endfunction

  // One clock: instr must equal the model word at pc before this edge's commit.
  task automatic step();
    logic [31:0] exp_i;
    exp_i = model_rd(pc);
    @(posedge clk);
    #1;
    if (reset) exp_i = 32'h0;
    check("instr", instr, exp_i);
    if (!pc_hold) pc = rand_addr();
  endtask

  task automatic idle();
    ren = 1'b0;
    wen = 1'b0;
    step();
    check("idle_valid", 32'(data_valid), 32'd0);
    check("idle_done", 32'(write_done), 32'd0);
    check("idle_err", 32'(error), 32'd0);
    check("idle_ready", 32'(ready), 32'd1);
    check("idle_dout", data_out, last_dout);
  endtask

  task automatic do_read(input logic [11:0] a);
    logic [31:0] exp_d;
    logic        oob;
    logic        busy_bad;
    int          lat;
    oob = (32'(a) >= DEPTH);
    check("rd_ready_pre", 32'(ready), 32'd1);
    data_addr = a;
    ren = 1'b1;
    wen = 1'b0;
    data_in = $urandom;
    bsv = 4'($urandom);
    step();
    ren = 1'b0;
    data_addr = 12'($urandom);
    exp_d = model_rd(a);
    lat = 0;
    busy_bad = 1'b0;
    while (!data_valid && lat < 40) begin
      if (ready || write_done || error) busy_bad = 1'b1;
      step();
      lat++;
    end
    check("rd_latency", 32'(lat), 32'(RD_LAT));
    check("rd_busy", 32'(busy_bad), 32'd0);
    check("rd_data", data_out, exp_d);
    check("rd_err", 32'(error), 32'(oob));
    check("rd_ready_post", 32'(ready), 32'd1);
    check("rd_no_done", 32'(write_done), 32'd0);
    last_dout = exp_d;
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
    logic oob;
    logic busy_bad;
    int   lat;
    oob = (32'(a) >= DEPTH);
    check("wr_ready_pre", 32'(ready), 32'd1);
    data_addr = a;
    ren = 1'b0;
    wen = 1'b1;
    data_in = d;
    bsv = be;
    step();
    wen = 1'b0;
    data_addr = 12'($urandom);
    data_in = $urandom;
    bsv = 4'($urandom);
    lat = 0;
    busy_bad = 1'b0;
    while (!write_done && lat < 40) begin
      if (ready || data_valid || error) busy_bad = 1'b1;
      step();
      lat++;
    end
    check("wr_latency", 32'(lat), 32'(WR_LAT));
    check("wr_busy", 32'(busy_bad), 32'd0);
    check("wr_err", 32'(error), 32'(oob));
    check("wr_ready_post", 32'(ready), 32'd1);
    check("wr_no_valid", 32'(data_valid), 32'd0);
    check("wr_dout_held", data_out, last_dout);
    if (!oob) model_mem[a[9:0]] = merge(model_mem[a[9:0]], d, be);
  endtask

  task automatic do_both(input logic [11:0] a);
    check("both_ready_pre", 32'(ready), 32'd1);
    data_addr = a;
    ren = 1'b1;
    wen = 1'b1;
    data_in = $urandom;
    bsv = 4'($urandom);
    step();
    ren = 1'b0;
    wen = 1'b0;
    check("both_err", 32'(error), 32'd1);
    check("both_ready", 32'(ready), 32'd1);
    check("both_valid", 32'(data_valid), 32'd0);
    check("both_done", 32'(write_done), 32'd0);
    check("both_dout", data_out, last_dout);
  endtask

  task automatic reset_mid_read(input logic [11:0] a);
    check("rr_ready_pre", 32'(ready), 32'd1);
    data_addr = a;
    ren = 1'b1;
    wen = 1'b0;
    step();
    ren = 1'b0;
    repeat (3) step();
    check("rr_no_valid_yet", 32'(data_valid), 32'd0);
    #2 reset = 1'b1;
    #1;
    check("rr_ready", 32'(ready), 32'd1);
    check("rr_dout", data_out, 32'h0);
    check("rr_valid", 32'(data_valid), 32'd0);
    check("rr_instr", instr, 32'h0);
    step();
    step();
    reset = 1'b0;
    last_dout = 32'h0;
    repeat (10) idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old_w;
    int unsigned op;
    reset = 1'b1;
    pc = '0;
    data_addr = '0;
    ren = 1'b0;
    wen = 1'b0;
    data_in = '0;
    bsv = '0;
    pc_hold = 1'b0;
    last_dout = '0;
    for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = 32'h0;

    step();
    step();
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_done", 32'(write_done), 32'd0);
    check("rst_err", 32'(error), 32'd0);
    check("rst_dout", data_out, 32'h0);
    reset = 1'b0;
    idle();

    do_write(12'd5, 32'hDEADBEEF, 4'hF);
    idle();
    do_write(12'd10, 32'hAABBCCDD, 4'hF);
    idle();
    do_read(12'd5);
    check("rd5_word", data_out, 32'hDEADBEEF);
    idle();

    pc_hold = 1'b1;
    pc = 12'd10;
    old_w = model_mem[10];
    do_write(12'd10, 32'h11223344, 4'b0101);
    check("haz_old_word", instr, old_w);
    do_read(12'd10);
    check("merge_word", data_out, 32'hAA22CC44);
    check("haz_new_word", instr, 32'hAA22CC44);
    pc_hold = 1'b0;
    idle();

    do_write(12'd10, 32'hFFFFFFFF, 4'b0000);
    do_read(12'd10);
    check("be_zero_word", data_out, 32'hAA22CC44);
    idle();

    do_both(12'd3);
    idle();

    do_read(12'd1500);
    check("oob_rd_zero", data_out, 32'h0);
    idle();
    do_write(12'd1500, 32'h5A5A5A5A, 4'hF);
    idle();
    do_read(12'd476);
    idle();

    do_read(12'd5);
    do_read(12'd10);
    idle();

    reset_mid_read(12'd5);

    for (int n = 0; n < 160; n++) begin
      op = $urandom_range(0, 9);
      if (op < 4) do_read(rand_addr());
      else if (op < 8) do_write(rand_addr(), $urandom, 4'($urandom));
      else if (op == 8) do_both(rand_addr());
      else idle();
      if ($urandom_range(0, 1) == 0) idle();
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
